// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, default sizes and bank-select codes for the systolic-array feeder.
package sa_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_STREAM, ST_DRAIN, ST_DONE} sa_state_e;
  localparam int SA_N = 8;
  localparam int SA_DW = 16;
  localparam int SA_K = 8;
  localparam logic X_BANK = 1'b0;
  localparam logic W_BANK = 1'b1;
endpackage

// File: rtl/sa_operand_bank.sv
// sa_operand_bank: K-deep operand store for one lane of one bank; contents are never reset.
module sa_operand_bank #(
  parameter int K = 8,
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(K)-1:0] wr_idx,
  input  logic [DW-1:0]        wr_data,
  input  logic [RW-1:0]        rd_idx,
  output logic [DW-1:0]        rd_data
);
  logic [DW-1:0] mem_q [K];
  always_ff @(posedge clk) if (we) mem_q[wr_idx] <= wr_data;
  always_comb rd_data = int'(rd_idx) < K ? mem_q[rd_idx[$clog2(K)-1:0]] : '0;
endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: loads X/W operand banks and streams them skewed onto the array edges for one matmul job.
module sa_feeder import sa_pkg::*; #(
  parameter int N = SA_N,
  parameter int DW = SA_DW,
  parameter int K = SA_K
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 IN_SEL,
  input  logic [$clog2(K)-1:0] IN_IDX,
  input  logic [N*DW-1:0]      IN_DATA,
  output logic [N*DW-1:0]      X_EDGE,
  output logic [N*DW-1:0]      W_EDGE,
  output logic                 SA_EN,
  output logic                 SA_CLR,
  output logic                 BUSY,
  output logic                 DONE
);
  localparam int CW = $clog2(K + N);
  sa_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N*DW-1:0] x_edge_q, x_edge_d, w_edge_q, w_edge_d, x_rd, w_rd;
  logic wr_en;
  assign IN_READY = !RST && (state_q == ST_IDLE || state_q == ST_DONE);
  assign wr_en = IN_VALID && IN_READY && int'(IN_IDX) < K;
  assign SA_CLR = state_q == ST_CLEAR;
  assign SA_EN = state_q == ST_STREAM || state_q == ST_DRAIN;
  assign BUSY = SA_CLR || SA_EN;
  assign DONE = state_q == ST_DONE;
  assign X_EDGE = x_edge_q;
  assign W_EDGE = w_edge_q;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = START ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: state_d = ST_STREAM;
      ST_STREAM: if (cnt_q == CW'(K + N - 2)) state_d = N > 1 ? ST_DRAIN : ST_DONE; else cnt_d = cnt_q + 1'b1;
      ST_DRAIN: if (cnt_q == CW'(N - 2)) state_d = ST_DONE; else cnt_d = cnt_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end
  // Lane i reads slot t-i; negative offsets map to an all-ones index, which the bank reads as 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CW-1:0] rd_idx;
    assign rd_idx = cnt_d >= CW'(i) ? cnt_d - CW'(i) : '1;
    sa_operand_bank #(.K(K), .DW(DW), .RW(CW)) u_x (
      .clk(CLK), .we(wr_en && IN_SEL == X_BANK), .wr_idx(IN_IDX), .wr_data(IN_DATA[i*DW +: DW]),
      .rd_idx(rd_idx), .rd_data(x_rd[i*DW +: DW])
    );
    sa_operand_bank #(.K(K), .DW(DW), .RW(CW)) u_w (
      .clk(CLK), .we(wr_en && IN_SEL == W_BANK), .wr_idx(IN_IDX), .wr_data(IN_DATA[i*DW +: DW]),
      .rd_idx(rd_idx), .rd_data(w_rd[i*DW +: DW])
    );
  end
  always_comb begin
    x_edge_d = state_d == ST_STREAM ? x_rd : '0;
    w_edge_d = state_d == ST_STREAM ? w_rd : '0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      x_edge_q <= '0;
      w_edge_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_edge_q <= x_edge_d;
      w_edge_q <= w_edge_d;
    end
  end
endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: scoreboard bench; the driver queues a per-cycle expected trace for each job, a negedge monitor pops and compares.
module tb_sa_feeder;
  import sa_pkg::*;
  localparam int N = 4, DW = 16, K = 4, IW = $clog2(K), KB = 5, IWB = $clog2(KB);
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_sel = 0;
  logic [IW-1:0] in_idx = '0;
  logic [N*DW-1:0] in_data = '0;
  logic in_ready, sa_en, sa_clr, busy, done;
  logic [N*DW-1:0] x_edge, w_edge;
  logic b_start = 0, b_valid = 0, b_sel = 0;
  logic [IWB-1:0] b_idx = '0;
  logic [N*DW-1:0] b_data = '0;
  logic b_rdy, b_en, b_clr, b_busy, b_done;
  logic [N*DW-1:0] b_x, b_w;
  always #5 clk = ~clk;

  sa_feeder #(.N(N), .DW(DW), .K(K)) dut (
    .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_SEL(in_sel),
    .IN_IDX(in_idx), .IN_DATA(in_data), .X_EDGE(x_edge), .W_EDGE(w_edge), .SA_EN(sa_en),
    .SA_CLR(sa_clr), .BUSY(busy), .DONE(done)
  );
  sa_feeder #(.N(N), .DW(DW), .K(KB)) dut_b (
    .CLK(clk), .RST(rst), .START(b_start), .IN_VALID(b_valid), .IN_READY(b_rdy), .IN_SEL(b_sel),
    .IN_IDX(b_idx), .IN_DATA(b_data), .X_EDGE(b_x), .W_EDGE(b_w), .SA_EN(b_en),
    .SA_CLR(b_clr), .BUSY(b_busy), .DONE(b_done)
  );

  typedef struct packed {
    logic [N*DW-1:0] x, w;
    logic en, clr, busy, done, rdy;
  } exp_t;
  exp_t q[$];
  logic [DW-1:0] mx [2][N][K];
  logic [DW-1:0] mb [2][N][KB];
  int n_chk = 0, n_fail = 0, cyc = 0, start_cyc = 0;

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, a, e);
    end
  endfunction

  function automatic exp_t stream_item(int t);
    exp_t e = '0;
    e.en = 1;
    e.busy = 1;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < K) begin
        e.x[i*DW +: DW] = mx[0][i][t-i];
        e.w[i*DW +: DW] = mx[1][i][t-i];
      end
    return e;
  endfunction

  task automatic push_job();
    exp_t e = '0;
    e.clr = 1;
    e.busy = 1;
    q.push_back(e);
    for (int t = 0; t < K + N - 1; t++) q.push_back(stream_item(t));
    e = '0;
    e.en = 1;
    e.busy = 1;
    for (int d = 0; d < N - 1; d++) q.push_back(e);
    e = '0;
    e.done = 1;
    e.rdy = 1;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    e = '0;
    e.rdy = !rst;
    if (q.size() > 0) e = q.pop_front();
    chk("x_edge", x_edge, e.x);
    chk("w_edge", w_edge, e.w);
    chk("sa_en", 64'(sa_en), 64'(e.en));
    chk("sa_clr", 64'(sa_clr), 64'(e.clr));
    chk("busy", 64'(busy), 64'(e.busy));
    chk("done", 64'(done), 64'(e.done));
    chk("in_ready", 64'(in_ready), 64'(e.rdy));
    if (done === 1'b1) chk("done_latency", 64'(cyc - start_cyc + 1), 64'd12);
    cyc++;
  end

  // One input cycle: drive, let the edge sample it, then apply its effect to the model.
  task automatic step(input logic s, input logic v, input logic sel, input int idx, input logic [N*DW-1:0] d);
    start = s;
    in_valid = v;
    in_sel = sel;
    in_idx = IW'(idx);
    in_data = d;
    @(posedge clk);
    if (!rst && q.size() == 0) begin
      if (v && idx < K) for (int i = 0; i < N; i++) mx[sel][i][idx] = d[i*DW +: DW];
      if (s) begin
        push_job();
        start_cyc = cyc;
      end
    end
    #1;
    start = 0;
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(0, 0, 0, 0, '0);
  endtask

  task automatic b_write(input logic sel, input int idx, input logic [N*DW-1:0] d);
    b_valid = 1;
    b_sel = sel;
    b_idx = IWB'(idx);
    b_data = d;
    @(posedge clk);
    if (idx < KB) for (int i = 0; i < N; i++) mb[sel][i][idx] = d[i*DW +: DW];
    #1;
    b_valid = 0;
  endtask

  initial begin
    logic [N*DW-1:0] d;
    repeat (4) @(posedge clk);
    #1;
    rst = 0;
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(16 * i + k + 1);
      step(0, 1, X_BANK, k, d);
      for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(256 + 16 * i + k);
      step(0, 1, W_BANK, k, d);
    end
    step(1, 0, 0, 0, '0);
    idle(2);
    step(1, 0, 0, 0, '0);
    step(0, 1, X_BANK, 0, {N{16'hFFFF}});
    idle(10);
    step(1, 0, 0, 0, '0);
    idle(13);
    step(1, 1, W_BANK, 2, {$urandom, $urandom});
    idle(13);
    step(1, 0, 0, 0, '0);
    idle(4);
    rst = 1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    idle(3);
    step(1, 0, 0, 0, '0);
    idle(11);
    step(1, 0, 0, 0, '0);
    idle(13);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, K - 1), {$urandom, $urandom});
    idle(14);
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < KB; k++) b_write(1'(s), k, {$urandom, $urandom});
    for (int s = 0; s < 2; s++)
      for (int k = KB; k < 8; k++) b_write(1'(s), k, {$urandom, $urandom});
    b_start = 1;
    @(posedge clk);
    #1;
    b_start = 0;
    @(negedge clk);
    chk("b_clr", 64'(b_clr), 64'd1);
    for (int t = 0; t < KB + N - 1; t++) begin
      logic [N*DW-1:0] ex, ew;
      ex = '0;
      ew = '0;
      for (int i = 0; i < N; i++)
        if (t - i >= 0 && t - i < KB) begin
          ex[i*DW +: DW] = mb[0][i][t-i];
          ew[i*DW +: DW] = mb[1][i][t-i];
        end
      @(negedge clk);
      chk("b_x_edge", b_x, ex);
      chk("b_w_edge", b_w, ew);
    end
    repeat (N + 1) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
